// File: rtl/stack_core.sv
// Multi-cycle stack machine. The operand stack lives in external RAM and
// instructions are fetched from a ROM with one cycle of read latency.
module stack_core #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int STACK_BASE  = 'h8000,
    parameter int STACK_DEPTH = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              retire,
    output logic              halted,
    output logic              error
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_OPND   = 4'd2;
    localparam logic [3:0] S_POPB   = 4'd3;
    localparam logic [3:0] S_POPA   = 4'd4;
    localparam logic [3:0] S_LDADR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_PUSH   = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [7:0] OP_IGN   = 8'h00;
    localparam logic [7:0] OP_IMM   = 8'h01;
    localparam logic [7:0] OP_STOM  = 8'h02;
    localparam logic [7:0] OP_LOADM = 8'h03;
    localparam logic [7:0] OP_JMP   = 8'h06;
    localparam logic [7:0] OP_BRA   = 8'h07;
    localparam logic [7:0] OP_ADD   = 8'h0B;
    localparam logic [7:0] OP_SUB   = 8'h0C;
    localparam logic [7:0] OP_MUL   = 8'h0D;
    localparam logic [7:0] OP_DIV   = 8'h0E;
    localparam logic [7:0] OP_MOD   = 8'h0F;
    localparam logic [7:0] OP_GRET  = 8'h10;
    localparam logic [7:0] OP_LESS  = 8'h11;
    localparam logic [7:0] OP_EQ    = 8'h12;
    localparam logic [7:0] OP_NEQ   = 8'h13;
    localparam logic [7:0] OP_AND   = 8'h14;
    localparam logic [7:0] OP_OR    = 8'h15;
    localparam logic [7:0] OP_XOR   = 8'h16;
    localparam logic [7:0] OP_NOT   = 8'h17;
    localparam logic [7:0] OP_HALT  = 8'h18;

    localparam logic [ADDR_W-1:0] SP_LO = ADDR_W'(STACK_BASE);
    localparam logic [ADDR_W-1:0] SP_HI = ADDR_W'(STACK_BASE + STACK_DEPTH);

    logic [3:0]        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, sp, sp_n;
    logic [7:0]        op, op_n;
    logic [DATA_W-1:0] opnd, opnd_n, bval, bval_n, res, res_n;
    logic              err_q, err_n;

    function automatic logic [DATA_W-1:0] alu(input logic [7:0] o,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        case (o)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_MUL:  alu = a * b;
            OP_DIV:  alu = (b == '0) ? '1 : a / b;
            OP_MOD:  alu = (b == '0) ? a : a % b;
            OP_GRET: alu = DATA_W'(a > b);
            OP_LESS: alu = DATA_W'(a < b);
            OP_EQ:   alu = DATA_W'(a == b);
            OP_NEQ:  alu = DATA_W'(a != b);
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            default: alu = '0;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        sp_n      = sp;
        op_n      = op;
        opnd_n    = opnd;
        bval_n    = bval;
        res_n     = res;
        err_n     = err_q;
        rom_addr  = pc;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        retire    = 1'b0;
        case (state)
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                // Prefetch the operand word so it lands in OPND.
                rom_addr = pc + ADDR_W'(1);
                op_n     = rom_data[7:0];
                case (rom_data[7:0])
                    OP_IGN: begin
                        retire  = 1'b1;
                        pc_n    = pc + ADDR_W'(1);
                        state_n = S_FETCH;
                    end
                    OP_IMM, OP_JMP, OP_BRA: state_n = S_OPND;
                    OP_STOM, OP_LOADM, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
                    OP_GRET, OP_LESS, OP_EQ, OP_NEQ, OP_AND, OP_OR, OP_XOR,
                    OP_NOT: state_n = S_POPB;
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_n = S_HALT;
                    end
                    default: begin
                        err_n   = 1'b1;
                        state_n = S_HALT;
                    end
                endcase
            end
            S_OPND: begin
                opnd_n = rom_data;
                case (op)
                    OP_JMP: begin
                        retire  = 1'b1;
                        pc_n    = ADDR_W'(rom_data);
                        state_n = S_FETCH;
                    end
                    OP_IMM: begin
                        res_n   = rom_data;
                        state_n = S_PUSH;
                    end
                    default: state_n = S_POPB;
                endcase
            end
            S_POPB: begin
                if (sp == SP_LO) begin
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else begin
                    ram_addr = sp - ADDR_W'(1);
                    sp_n     = sp - ADDR_W'(1);
                    if (op == OP_LOADM)                    state_n = S_LDADR;
                    else if (op == OP_NOT || op == OP_BRA) state_n = S_EXEC;
                    else                                   state_n = S_POPA;
                end
            end
            S_POPA: begin
                bval_n = ram_rdata;
                if (sp == SP_LO) begin
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else begin
                    ram_addr = sp - ADDR_W'(1);
                    sp_n     = sp - ADDR_W'(1);
                    state_n  = S_EXEC;
                end
            end
            S_LDADR: begin
                bval_n   = ram_rdata;
                ram_addr = ADDR_W'(ram_rdata);
                state_n  = S_EXEC;
            end
            S_EXEC: begin
                // ram_rdata holds the last popped word (a, or b for unary ops).
                case (op)
                    OP_BRA: begin
                        retire  = 1'b1;
                        pc_n    = (ram_rdata == '0) ? ADDR_W'(opnd) : pc + ADDR_W'(2);
                        state_n = S_FETCH;
                    end
                    OP_STOM: begin
                        ram_addr  = ADDR_W'(bval);
                        ram_wdata = ram_rdata;
                        ram_we    = 1'b1;
                        retire    = 1'b1;
                        pc_n      = pc + ADDR_W'(1);
                        state_n   = S_FETCH;
                    end
                    OP_LOADM: begin
                        res_n   = ram_rdata;
                        state_n = S_PUSH;
                    end
                    OP_NOT: begin
                        res_n   = ~ram_rdata;
                        state_n = S_PUSH;
                    end
                    default: begin
                        res_n   = alu(op, ram_rdata, bval);
                        state_n = S_PUSH;
                    end
                endcase
            end
            S_PUSH: begin
                if (sp == SP_HI) begin
                    err_n   = 1'b1;
                    state_n = S_HALT;
                end else begin
                    ram_addr  = sp;
                    ram_wdata = res;
                    ram_we    = 1'b1;
                    sp_n      = sp + ADDR_W'(1);
                    retire    = 1'b1;
                    pc_n      = pc + ((op == OP_IMM) ? ADDR_W'(2) : ADDR_W'(1));
                    state_n   = S_FETCH;
                end
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_FETCH;
            pc    <= '0;
            sp    <= SP_LO;
            op    <= '0;
            opnd  <= '0;
            bval  <= '0;
            res   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            sp    <= sp_n;
            op    <= op_n;
            opnd  <= opnd_n;
            bval  <= bval_n;
            res   <= res_n;
            err_q <= err_n;
        end
    end

    assign halted = (state == S_HALT);
    assign error  = err_q;

endmodule

// File: tb/tb_stack_core.sv
// Directed bench for stack_core: small programs in a ROM model, RAM model with
// write logging, hand-computed results checked after each program halts.
module tb_stack_core;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] rom_addr, rom_data, ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, retire, halted, error;

    stack_core #(.DATA_W(16), .ADDR_W(16), .STACK_BASE('h8000), .STACK_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .retire(retire), .halted(halted), .error(error)
    );

    always #5 clock = ~clock;

    logic [15:0] rom [0:255];
    logic [15:0] ram [0:65535];

    always @(posedge clock) begin
        rom_data  <= rom[rom_addr[7:0]];
        ram_rdata <= ram[ram_addr];
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    int          nwr, nret, nret_halt, n100;
    logic [15:0] last_wa, last_wd;

    always @(negedge clock) begin
        if (ram_we) begin
            nwr++;
            last_wa = ram_addr;
            last_wd = ram_wdata;
            if (ram_addr == 16'h0100) n100++;
        end
        if (retire) begin
            if (rom_data[7:0] == 8'h18) nret_halt++;
            else                        nret++;
        end
    end

    int npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    int pp;
    task automatic clr();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0018;
        pp = 0;
    endtask
    task automatic p(input logic [15:0] w);
        rom[pp] = w;
        pp++;
    endtask

    // Reset, release, run until halted (bounded), then idle a few cycles.
    task automatic run(input string tag, output int cyc);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        nwr = 0; nret = 0; nret_halt = 0; n100 = 0; last_wa = '0; last_wd = '0;
        reset_n = 1'b1;
        cyc = 0;
        while (!halted && cyc < 500) begin
            cyc++;
            @(negedge clock);
        end
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        repeat (3) @(negedge clock);
    endtask

    logic [7:0]  t_op [15] = '{8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h0E, 8'h0F, 8'h10,
                               8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    logic [15:0] t_a  [15] = '{16'h0003, 16'h0003, 16'h0101, 16'h0009, 16'h0009, 16'h0017,
                               16'h0017, 16'h0003, 16'h0003, 16'h0005, 16'h0005, 16'hF0F0,
                               16'hF0F0, 16'hF0F0, 16'h00F0};
    logic [15:0] t_b  [15] = '{16'h0005, 16'h0005, 16'h0101, 16'h0000, 16'h0000, 16'h0005,
                               16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h3C3C,
                               16'h0F00, 16'hFF00, 16'h0000};
    logic [15:0] t_r  [15] = '{16'h0008, 16'hFFFE, 16'h0201, 16'hFFFF, 16'h0009, 16'h0004,
                               16'h0003, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h3030,
                               16'hFFF0, 16'h0FF0, 16'hFF0F};

    task automatic load_store_prog();
        clr();
        p(16'h0001); p(16'h0003); p(16'h0001); p(16'h0004); p(16'h000B);
        p(16'h0001); p(16'h0100); p(16'h0002); p(16'h0018);
    endtask

    initial begin
        int cyc;

        // Reset values while reset_n is held low.
        clr();
        repeat (2) @(negedge clock);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        chk("rst_ctrl", {28'h0, ram_we, retire, halted, error}, 32'h0);
        chk("rst_sp", 32'(dut.sp), 32'h8000);

        // 3+4 stored to ram[0100].
        load_store_prog();
        run("store", cyc);
        chk("store_cycles", 32'(cyc), 32'd25);
        chk("store_n100", 32'(n100), 32'd1);
        chk("store_val", 32'(ram[16'h0100]), 32'h7);
        chk("store_sp", 32'(dut.sp), 32'h8000);
        chk("store_err", 32'(error), 32'd0);
        chk("store_retire", 32'(nret), 32'd5);
        chk("store_halt_retire", 32'(nret_halt), 32'd1);

        // LOADM reads back the word stored above.
        clr();
        p(16'h0001); p(16'h0100); p(16'h0003); p(16'h0018);
        run("loadm", cyc);
        chk("loadm_val", {last_wa, last_wd}, {16'h8000, 16'h0007});

        // ALU table: push a (and b), apply op, result lands in the first slot.
        for (int i = 0; i < 15; i++) begin
            clr();
            p(16'h0001); p(t_a[i]);
            if (t_op[i] != 8'h17) begin
                p(16'h0001); p(t_b[i]);
            end
            p({8'hA5, t_op[i]});  // upper opcode bits must be ignored
            run("alu", cyc);
            chk($sformatf("alu_op%02h_%0d", t_op[i], i), {last_wa, last_wd}, {16'h8000, t_r[i]});
        end

        // BRA taken / not taken, JMP.
        clr();
        p(16'h0001); p(16'h0000); p(16'h0007); p(16'h0020);
        p(16'h0001); p(16'hBBBB);
        pp = 'h20; p(16'h0001); p(16'hAAAA);
        run("bra_taken", cyc);
        chk("bra_taken", 32'(last_wd), 32'hAAAA);
        rom[1] = 16'h0005;
        run("bra_fall", cyc);
        chk("bra_fall", 32'(last_wd), 32'hBBBB);
        clr();
        p(16'h0006); p(16'h0010);
        pp = 'h10; p(16'h0001); p(16'hCCCC);
        run("jmp", cyc);
        chk("jmp", {last_wd, 16'(nret)}, {16'hCCCC, 16'd2});

        // Underflow: ADD on an empty stack.
        clr();
        p(16'h000B);
        run("under", cyc);
        chk("under_err", 32'(error), 32'd1);
        chk("under_nwr", 32'(nwr), 32'd0);
        chk("under_sp", 32'(dut.sp), 32'h8000);

        // Overflow with depth 4.
        clr();
        for (int i = 1; i <= 5; i++) begin
            p(16'h0001); p(16'(i));
        end
        run("over", cyc);
        chk("over_nwr", 32'(nwr), 32'd4);
        chk("over_err", 32'(error), 32'd1);
        chk("over_sp", 32'(dut.sp), 32'h8004);
        chk("over_retire", 32'(nret), 32'd4);

        // Illegal opcode: error, no retire.
        clr();
        p(16'h0005);
        run("illegal", cyc);
        chk("illegal", {error, 31'(nret + nret_halt)}, {1'b1, 31'd0});

        // Plain HALT.
        clr();
        run("halt", cyc);
        chk("halt", {error, 31'(nret_halt)}, {1'b0, 31'd1});

        // Reset during POPA of ADD (cycle 12 after release), then rerun.
        load_store_prog();
        ram[16'h0100] = 16'h0000;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (11) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_pc", 32'(rom_addr), 32'h0);
        chk("midrst_sp", 32'(dut.sp), 32'h8000);
        chk("midrst_we", {30'h0, ram_we, halted}, 32'h0);
        run("rerun", cyc);
        chk("rerun_cycles", 32'(cyc), 32'd25);
        chk("rerun_val", {16'(n100), ram[16'h0100]}, {16'd1, 16'h0007});

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
